mem_wb_stage: RTL and testbench

Memory stage of the five-stage pipelined MIPS core, directly downstream of the EX/MEM latch. It drives the data-memory request from the latched EX/MEM fields and holds the pipeline until the cache answers. It selects the write-back value and registers the MEM/WB fields consumed by the register file. It also owns halt sequencing and a saturating memory-stall cycle counter.

---
 rtl/mem_wb_stage.sv | 130 +++++++++++++
 tb/tb_mem_wb_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage of the five-stage MIPS pipeline: drives the data-cache request,
// stalls until dhit, registers the MEM/WB fields and sequences HALT.
module mem_wb_stage #(
  parameter int unsigned STALLCNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            memtoreg,
  input  logic                  regwrite,
  input  logic                  dmemREN,
  input  logic                  dmemWEN,
  input  logic                  halt,
  input  logic [31:0]           rdat2,
  input  logic [31:0]           npc,
  input  logic [31:0]           aluResult,
  input  logic [4:0]            branchDest,
  input  logic [31:0]           upper16,
  input  logic                  dhit,
  input  logic [31:0]           dmemload,
  output logic [31:0]           dmemaddr,
  output logic [31:0]           dmemstore,
  output logic                  dmemREN_out,
  output logic                  dmemWEN_out,
  output logic                  mem_stall,
  output logic                  wb_regwrite,
  output logic [4:0]            wb_wsel,
  output logic [31:0]           wb_wdat,
  output logic                  wb_halt,
  output logic [STALLCNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    wb_regwrite_q, wb_regwrite_d;
  logic [4:0]              wb_wsel_q, wb_wsel_d;
  logic [31:0]             wb_wdat_q, wb_wdat_d;
  logic                    wb_halt_q, wb_halt_d;
  logic [STALLCNT_W-1:0]   stall_q, stall_d;

  logic                    req;
  logic [31:0]             wdat_sel;

  // Request and stall are combinational so the cache sees them this cycle
  always_comb begin
    req         = (dmemREN | dmemWEN) & (state_q != HALTED) & ~RST;
    dmemWEN_out = req & dmemWEN;
    dmemREN_out = req & dmemREN & ~dmemWEN;
    mem_stall   = req & ~dhit;
    dmemaddr    = {aluResult[31:2], 2'b00};
    dmemstore   = rdat2;
  end

  always_comb begin
    wdat_sel = aluResult;
    case (memtoreg)
      2'd0:    wdat_sel = aluResult;
      2'd1:    wdat_sel = dmemload;
      2'd2:    wdat_sel = npc;
      default: wdat_sel = upper16;
    endcase
  end

  // Next-state, MEM/WB capture and saturating stall counter
  always_comb begin
    state_d       = state_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_wsel_d     = wb_wsel_q;
    wb_wdat_d     = wb_wdat_q;
    wb_halt_d     = wb_halt_q;
    stall_d       = stall_q;

    case (state_q)
      IDLE: begin
        if (halt && !mem_stall)  state_d = HALTED;
        else if (req && !dhit)   state_d = BUSY;
      end
      BUSY: begin
        if (halt && !mem_stall)  state_d = HALTED;
        else if (dhit)           state_d = IDLE;
      end
      default: state_d = HALTED;
    endcase

    if (state_q == HALTED) begin
      wb_regwrite_d = 1'b0;
    end else if (mem_stall) begin
      // Bubble: hold sel/data but suppress the write so it is not repeated
      wb_regwrite_d = 1'b0;
    end else begin
      wb_regwrite_d = regwrite;
      wb_wsel_d     = branchDest;
      wb_wdat_d     = wdat_sel;
      wb_halt_d     = halt;
    end

    if (mem_stall && (stall_q != '1)) begin
      stall_d = stall_q + STALLCNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      wb_regwrite_q <= 1'b0;
      wb_wsel_q     <= 5'd0;
      wb_wdat_q     <= 32'd0;
      wb_halt_q     <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_wsel_q     <= wb_wsel_d;
      wb_wdat_q     <= wb_wdat_d;
      wb_halt_q     <= wb_halt_d;
      stall_q       <= stall_d;
    end
  end

  assign wb_regwrite  = wb_regwrite_q;
  assign wb_wsel      = wb_wsel_q;
  assign wb_wdat      = wb_wdat_q;
  assign wb_halt      = wb_halt_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; a second instance with a 2-bit counter
// shares all inputs to exercise counter saturation.
module tb_mem_wb_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  memtoreg;
  logic        regwrite, dmemREN, dmemWEN, halt, dhit;
  logic [31:0] rdat2, npc, aluResult, upper16, dmemload;
  logic [4:0]  branchDest;

  logic [31:0] dmemaddr, dmemstore, wb_wdat;
  logic        dmemREN_out, dmemWEN_out, mem_stall, wb_regwrite, wb_halt;
  logic [4:0]  wb_wsel;
  logic [15:0] stall_cycles;

  logic [31:0] dmemaddr2, dmemstore2, wb_wdat2;
  logic        dmemREN_out2, dmemWEN_out2, mem_stall2, wb_regwrite2, wb_halt2;
  logic [4:0]  wb_wsel2;
  logic [1:0]  stall_cycles2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mem_wb_stage #(.STALLCNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .memtoreg(memtoreg), .regwrite(regwrite),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt), .rdat2(rdat2),
    .npc(npc), .aluResult(aluResult), .branchDest(branchDest),
    .upper16(upper16), .dhit(dhit), .dmemload(dmemload),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemREN_out(dmemREN_out),
    .dmemWEN_out(dmemWEN_out), .mem_stall(mem_stall),
    .wb_regwrite(wb_regwrite), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .wb_halt(wb_halt), .stall_cycles(stall_cycles)
  );

  mem_wb_stage #(.STALLCNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .memtoreg(memtoreg), .regwrite(regwrite),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt), .rdat2(rdat2),
    .npc(npc), .aluResult(aluResult), .branchDest(branchDest),
    .upper16(upper16), .dhit(dhit), .dmemload(dmemload),
    .dmemaddr(dmemaddr2), .dmemstore(dmemstore2), .dmemREN_out(dmemREN_out2),
    .dmemWEN_out(dmemWEN_out2), .mem_stall(mem_stall2),
    .wb_regwrite(wb_regwrite2), .wb_wsel(wb_wsel2), .wb_wdat(wb_wdat2),
    .wb_halt(wb_halt2), .stall_cycles(stall_cycles2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    memtoreg = 2'd0; regwrite = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    halt = 1'b0; dhit = 1'b0; rdat2 = '0; npc = '0; aluResult = '0;
    upper16 = '0; dmemload = '0; branchDest = '0;
  endtask

  logic [1:0] st;

  initial begin
    clear_inputs();

    // Reset with a pending load: no request, no stall
    RST = 1'b1; dmemREN = 1'b1; aluResult = 32'h100;
    settle();
    check("rst_ren_out", 32'(dmemREN_out), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    tick();
    tick();
    check("rst_ren_out2", 32'(dmemREN_out), 32'd0);
    check("rst_stall2", 32'(mem_stall), 32'd0);
    RST = 1'b0; clear_inputs();
    settle();
    check("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("rst_wb_wsel", 32'(wb_wsel), 32'd0);
    check("rst_wb_wdat", wb_wdat, 32'd0);
    check("rst_wb_halt", 32'(wb_halt), 32'd0);
    check("rst_stall_cycles", 32'(stall_cycles), 32'd0);

    // ALU op
    regwrite = 1'b1; memtoreg = 2'd0; aluResult = 32'h0000_1234; branchDest = 5'd5;
    settle();
    check("alu_stall", 32'(mem_stall), 32'd0);
    tick();
    check("alu_wb_regwrite", 32'(wb_regwrite), 32'd1);
    check("alu_wb_wsel", 32'(wb_wsel), 32'd5);
    check("alu_wb_wdat", wb_wdat, 32'h0000_1234);
    check("alu_stall_cycles", 32'(stall_cycles), 32'd0);

    // Load miss: three stall cycles, then hit with DEADBEEF
    regwrite = 1'b1; memtoreg = 2'd1; dmemREN = 1'b1; aluResult = 32'h0000_0103;
    branchDest = 5'd7; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("ld_addr", dmemaddr, 32'h0000_0100);
      check("ld_stall", 32'(mem_stall), 32'd1);
      check("ld_ren_out", 32'(dmemREN_out), 32'd1);
      tick();
      check("ld_bubble_regwrite", 32'(wb_regwrite), 32'd0);
      check("ld_bubble_wdat", wb_wdat, 32'h0000_1234);
    end
    dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
    settle();
    check("ld_hit_stall", 32'(mem_stall), 32'd0);
    check("ld_hit_addr", dmemaddr, 32'h0000_0100);
    tick();
    check("ld_wb_wdat", wb_wdat, 32'hDEAD_BEEF);
    check("ld_wb_regwrite", 32'(wb_regwrite), 32'd1);
    check("ld_wb_wsel", 32'(wb_wsel), 32'd7);
    check("ld_stall_cycles", 32'(stall_cycles), 32'd3);
    check("ld_stall_cycles_w2", 32'(stall_cycles2), 32'd3);
    clear_inputs();

    // Store with both strobes and an immediate hit
    dmemREN = 1'b1; dmemWEN = 1'b1; rdat2 = 32'hCAFE_F00D; aluResult = 32'h0000_0200;
    dhit = 1'b1;
    settle();
    check("st_wen_out", 32'(dmemWEN_out), 32'd1);
    check("st_ren_out", 32'(dmemREN_out), 32'd0);
    check("st_store", dmemstore, 32'hCAFE_F00D);
    check("st_stall", 32'(mem_stall), 32'd0);
    tick();
    check("st_wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("st_stall_cycles", 32'(stall_cycles), 32'd3);
    clear_inputs();

    // Link (npc) and LUI write-back sources
    regwrite = 1'b1; memtoreg = 2'd2; npc = 32'h0000_0044; branchDest = 5'd31;
    tick();
    check("jal_wb_wdat", wb_wdat, 32'h0000_0044);
    check("jal_wb_wsel", 32'(wb_wsel), 32'd31);
    memtoreg = 2'd3; upper16 = 32'hABCD_0000; branchDest = 5'd3;
    tick();
    check("lui_wb_wdat", wb_wdat, 32'hABCD_0000);
    check("lui_wb_wsel", 32'(wb_wsel), 32'd3);
    clear_inputs();

    // Two more stall cycles: 16-bit counter reaches 5, 2-bit counter holds at 3
    dmemREN = 1'b1; aluResult = 32'h0000_0400;
    tick();
    tick();
    dhit = 1'b1;
    tick();
    check("sat_stall_cycles", 32'(stall_cycles), 32'd5);
    check("sat_stall_cycles_w2", 32'(stall_cycles2), 32'd3);
    clear_inputs();

    // Reset in BUSY: request drops at once, state IDLE, counter cleared
    dmemREN = 1'b1; regwrite = 1'b1; aluResult = 32'h0000_0500; dhit = 1'b0;
    tick();
    st = dut.state_q;
    check("busy_state", 32'(st), 32'd1);
    RST = 1'b1;
    settle();
    check("busy_rst_ren_out", 32'(dmemREN_out), 32'd0);
    check("busy_rst_stall", 32'(mem_stall), 32'd0);
    tick();
    RST = 1'b0; clear_inputs();
    settle();
    st = dut.state_q;
    check("busy_rst_state", 32'(st), 32'd0);
    check("busy_rst_stall_cycles", 32'(stall_cycles), 32'd0);
    check("busy_rst_wb_regwrite", 32'(wb_regwrite), 32'd0);

    // Halt behind a store miss: taken only on completion, then sticky
    dmemWEN = 1'b1; halt = 1'b1; aluResult = 32'h0000_0300; rdat2 = 32'h1111_2222;
    dhit = 1'b0;
    settle();
    check("hlt_wen_out", 32'(dmemWEN_out), 32'd1);
    check("hlt_stall", 32'(mem_stall), 32'd1);
    tick();
    check("hlt_wb_halt_1", 32'(wb_halt), 32'd0);
    tick();
    check("hlt_wb_halt_2", 32'(wb_halt), 32'd0);
    dhit = 1'b1;
    settle();
    check("hlt_hit_stall", 32'(mem_stall), 32'd0);
    tick();
    check("hlt_wb_halt", 32'(wb_halt), 32'd1);
    check("hlt_wb_wdat", wb_wdat, 32'h0000_0300);
    clear_inputs();
    regwrite = 1'b1; dmemREN = 1'b1; aluResult = 32'h0000_0055; branchDest = 5'd9;
    settle();
    check("hltd_ren_out", 32'(dmemREN_out), 32'd0);
    check("hltd_stall", 32'(mem_stall), 32'd0);
    tick();
    tick();
    check("hltd_wb_regwrite", 32'(wb_regwrite), 32'd0);
    check("hltd_wb_halt", 32'(wb_halt), 32'd1);
    check("hltd_wb_wdat", wb_wdat, 32'h0000_0300);
    check("hltd_stall_cycles", 32'(stall_cycles), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
